// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl -- iterative AES-128 key-schedule sequencer.
//
// Accepts a 128-bit cipher key and streams round keys 0..NUM_ROUNDS to the
// round engine, one per cycle, over a valid/ready handshake. A single 4-byte
// S-box word path is shared by all rounds.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   key_valid/ready   cipher key handshake (ready only while idle)
//   key[127:0]        cipher key, word0 = key[127:96]
//   abort             synchronous cancel of the current expansion
//   rk_valid/ready    round key handshake
//   rk[127:0]         round key, word0 = rk[127:96]
//   rk_round[3:0]     round index of rk
//   rk_last           rk holds the final round key
//   busy              expansion in progress
//
// Optional build macro KEY_SCHED_CACHE_EN adds a round-key cache:
//   rd_round[3:0] in, rd_key[127:0] out, cache_valid out.
//   Every handshaken round key is stored at its round index so the decrypt
//   path can read keys in reverse order without re-expanding.

// One S-box byte lane: multiplicative inverse in GF(2^8) followed by the
// affine transform. The inverse is a^254, built from the squares a^2..a^128.
module aes_key_sched_sbox (
   input  logic [7:0] a,
   output logic [7:0] s
);
   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] m;
      p = 8'h00;
      m = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p = p ^ m;
         m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] inv;
   logic [7:0] sq;

   always_comb begin
      sq  = a;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gmul(sq, sq);
         inv = gmul(inv, sq);
      end
      // a == 0 propagates to inv == 0, which gives the required s == 8'h63
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end
endmodule

module aes_key_sched_ctrl #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [127:0] key,
   input  logic         abort,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk,
   output logic [3:0]   rk_round,
   output logic         rk_last,
`ifdef KEY_SCHED_CACHE_EN
   input  logic [3:0]   rd_round,
   output logic [127:0] rd_key,
   output logic         cache_valid,
`endif
   output logic         busy
);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_EMIT = 1'b1;
   localparam logic [3:0] LAST   = 4'(NUM_ROUNDS);

   logic [0:0] state;
   logic [7:0] rcon;

   // Round-key word path: t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
   logic [31:0]  w3, rot_w, sub_w, t_w;
   logic [127:0] rk_next;

   assign w3    = rk[31:0];
   assign rot_w = {w3[23:0], w3[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_key_sched_sbox u_sbox (
         .a (rot_w[8*g +: 8]),
         .s (sub_w[8*g +: 8])
      );
   end

   assign t_w = sub_w ^ {rcon, 24'h000000};

   // Each new word chains off the previous new word (w0..w3 of the next key).
   always_comb begin
      rk_next[127:96] = rk[127:96] ^ t_w;
      rk_next[95:64]  = rk[95:64]  ^ rk_next[127:96];
      rk_next[63:32]  = rk[63:32]  ^ rk_next[95:64];
      rk_next[31:0]   = rk[31:0]   ^ rk_next[63:32];
   end

   assign key_ready = (state == S_IDLE);
   assign rk_valid  = (state == S_EMIT);
   assign busy      = (state != S_IDLE);
   assign rk_last   = rk_valid && (rk_round == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         rk       <= '0;
         rk_round <= '0;
         rcon     <= 8'h01;
      end else if (abort) begin
         // rk/rk_round intentionally retained
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (key_valid) begin
                  state    <= S_EMIT;
                  rk       <= key;
                  rk_round <= '0;
                  rcon     <= 8'h01;
               end
            end
            S_EMIT: begin
               if (rk_ready) begin
                  if (rk_round == LAST) begin
                     state <= S_IDLE;
                  end else begin
                     rk       <= rk_next;
                     rk_round <= rk_round + 4'd1;
                     rcon     <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef KEY_SCHED_CACHE_EN
   logic [127:0] cache [0:10];
   logic         rk_hs;
   logic         key_acc;

   assign rk_hs   = rk_valid && rk_ready;
   assign key_acc = key_valid && key_ready;

   always_ff @(posedge clk) begin
      if (rst || abort || key_acc) cache_valid <= 1'b0;
      else if (rk_hs && (rk_round == LAST)) cache_valid <= 1'b1;

      if (!rst && !abort && rk_hs) cache[rk_round] <= rk;
   end

   assign rd_key = (rd_round <= LAST) ? cache[rd_round] : '0;
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
module tb_aes_key_sched_ctrl;
   logic         clk;
   logic         rst;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] key;
   logic         abort;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk;
   logic [3:0]   rk_round;
   logic         rk_last;
   logic         busy;
`ifdef KEY_SCHED_CACHE_EN
   logic [3:0]   rd_round;
   logic [127:0] rd_key;
   logic         cache_valid;
`endif

   aes_key_sched_ctrl #(.NUM_ROUNDS(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key       (key),
      .abort     (abort),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .rk        (rk),
      .rk_round  (rk_round),
      .rk_last   (rk_last),
`ifdef KEY_SCHED_CACHE_EN
      .rd_round  (rd_round),
      .rd_key    (rd_key),
      .cache_valid (cache_valid),
`endif
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0]   sb [256];
   logic [127:0] exp_keys [0:10];

   function automatic int gm(input int a, input int b);
      int r;
      r = 0;
      while (b != 0) begin
         if ((b & 1) != 0) r = r ^ a;
         a = a << 1;
         if ((a & 256) != 0) a = a ^ 283;
         b = b >> 1;
      end
      return r;
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         int inv;
         int s;
         inv = 0;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gm(x, y) == 1) inv = y;
         s = 99;
         for (int i = 0; i < 5; i++)
            s = s ^ (((inv << i) | (inv >> (8 - i))) & 255);
         sb[x] = 8'(s);
      end
   endtask

   // FIPS-197 KeyExpansion over a flat word array
   task automatic model_expand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] tmp;
      int rc;
      rc = 1;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
            tmp = tmp ^ {8'(rc), 24'h0};
            rc = rc * 2;
            if (rc > 255) rc = rc ^ 283;
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++)
         exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // ---------------- expansion driver ----------------
   logic [127:0] got [0:10];
   int n_got, vcyc, stable_err, order_err, last_err, inj_err;
   bit done;

   // Called at a negedge with the DUT idle; returns at the negedge after
   // the final handshake.
   task automatic run_key(input logic [127:0] k, input bit rand_rdy, input bit inject);
      bit stalled;
      bit rdy;
      logic [127:0] prev_rk;
      logic [3:0] prev_rnd;
      int cyc;
      n_got = 0; vcyc = 0; stable_err = 0; order_err = 0; last_err = 0; inj_err = 0;
      done = 0; stalled = 0; cyc = 0; prev_rk = '0; prev_rnd = '0;
      chk("key_ready_before_accept", {127'h0, key_ready}, 128'h1);
      key = k; key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
      while (!done && cyc < 300) begin
         if (inject && cyc == 2) begin
            key = ~k; key_valid = 1'b1;
            if (key_ready) inj_err++;
         end else key_valid = 1'b0;
         if (stalled && (rk !== prev_rk || rk_round !== prev_rnd)) stable_err++;
         rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         rk_ready = rdy;
         if (rk_valid) begin
            vcyc++;
            if (rk_last !== (rk_round == 4'd10)) last_err++;
         end
         if (rk_valid && rdy) begin
            if (n_got > 10 || rk_round != 4'(n_got)) order_err++;
            else got[n_got] = rk;
            n_got++;
            if (rk_round == 4'd10) done = 1;
         end
         stalled = rk_valid && !rdy;
         prev_rk = rk; prev_rnd = rk_round;
         @(negedge clk);
         cyc++;
      end
      rk_ready = 1'b0; key_valid = 1'b0;
      chk("expand_completed", {127'h0, done}, 128'h1);
   endtask

   task automatic cmp_all(input string tag);
      for (int r = 0; r < 11; r++)
         chk($sformatf("%s_round%0d", tag, r), got[r], exp_keys[r]);
      chk({tag, "_order"}, 128'(order_err), 128'h0);
      chk({tag, "_last_flag"}, 128'(last_err), 128'h0);
      chk({tag, "_idle_after"}, {126'h0, rk_valid, key_ready}, 128'h1);
   endtask

   typedef struct {
      logic [127:0] key;
      logic [127:0] r1;
      logic [127:0] r10;
   } vec_t;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   initial begin
      vec_t tbl [2];
      logic [127:0] k2;
      int guard;

      tbl[0] = '{FIPS_KEY, 128'ha0fafe1788542cb123a339392a6c7605,
                 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      tbl[1] = '{128'h0, 128'h62636363626363636263636362636363,
                 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

      rst = 1'b1; key_valid = 1'b0; key = '0; abort = 1'b0; rk_ready = 1'b0;
`ifdef KEY_SCHED_CACHE_EN
      rd_round = '0;
`endif
      build_sbox();
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_key_ready", {127'h0, key_ready}, 128'h1);
      chk("rst_rk_valid",  {127'h0, rk_valid}, 128'h0);
      chk("rst_busy",      {127'h0, busy}, 128'h0);
      chk("rst_rk",        rk, 128'h0);
      chk("rst_rk_round_last", {123'h0, rk_round, rk_last}, 128'h0);
      rst = 1'b0;
      @(negedge clk);

      // table vectors, rk_ready held high
      for (int v = 0; v < 2; v++) begin
         model_expand(tbl[v].key);
         run_key(tbl[v].key, 1'b0, 1'b0);
         chk($sformatf("tbl%0d_round0", v),  got[0],  tbl[v].key);
         chk($sformatf("tbl%0d_round1", v),  got[1],  tbl[v].r1);
         chk($sformatf("tbl%0d_round10", v), got[10], tbl[v].r10);
         chk($sformatf("tbl%0d_valid_cycles", v), 128'(vcyc), 128'd11);
         cmp_all($sformatf("tbl%0d", v));
      end

      // FIPS key with random backpressure
      model_expand(FIPS_KEY);
      run_key(FIPS_KEY, 1'b1, 1'b0);
      cmp_all("fips_bp");
      chk("fips_bp_stable", 128'(stable_err), 128'h0);

`ifdef KEY_SCHED_CACHE_EN
      chk("cache_valid_after_run", {127'h0, cache_valid}, 128'h1);
      rd_round = 4'd10; #1;
      chk("cache_rd10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      rd_round = 4'd5; #1;
      chk("cache_rd5", rd_key, exp_keys[5]);
      rd_round = 4'd0; #1;
      chk("cache_rd0", rd_key, FIPS_KEY);
      rd_round = 4'd11; #1;
      chk("cache_rd11_zero", rd_key, 128'h0);
      @(negedge clk);
      key = 128'h00112233445566778899aabbccddeeff; key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
      chk("cache_valid_cleared_on_accept", {127'h0, cache_valid}, 128'h0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      @(negedge clk);
`endif

      // new key offered while busy is ignored
      model_expand(FIPS_KEY);
      run_key(FIPS_KEY, 1'b0, 1'b1);
      cmp_all("inject");
      chk("inject_key_ready_low", 128'(inj_err), 128'h0);

      // random keys with random backpressure
      for (int n = 0; n < 5; n++) begin
         k2 = {$urandom, $urandom, $urandom, $urandom};
         model_expand(k2);
         run_key(k2, 1'b1, 1'b0);
         cmp_all($sformatf("rand%0d", n));
         chk($sformatf("rand%0d_stable", n), 128'(stable_err), 128'h0);
      end

      // abort on round 4
      model_expand(FIPS_KEY);
      key = FIPS_KEY; key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0; rk_ready = 1'b1;
      guard = 0;
      while (!(rk_valid && rk_round == 4'd4) && guard < 30) begin
         @(negedge clk);
         guard++;
      end
      chk("abort_reached_round4", {127'h0, rk_valid && rk_round == 4'd4}, 128'h1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0; rk_ready = 1'b0;
      chk("abort_rk_valid", {127'h0, rk_valid}, 128'h0);
      chk("abort_busy_ready", {126'h0, busy, key_ready}, 128'h1);
      chk("abort_keeps_round", {124'h0, rk_round}, 128'd4);
      chk("abort_keeps_rk", rk, exp_keys[4]);
`ifdef KEY_SCHED_CACHE_EN
      chk("abort_cache_valid", {127'h0, cache_valid}, 128'h0);
`endif
      rk_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_no_round5", {127'h0, rk_valid}, 128'h0);
      rk_ready = 1'b0;

      // abort together with key_valid in idle: no accept
      abort = 1'b1; key_valid = 1'b1; key = 128'hdeadbeef_00000000_cafef00d_12345678;
      @(negedge clk);
      abort = 1'b0; key_valid = 1'b0;
      chk("abort_idle_no_accept", {127'h0, rk_valid}, 128'h0);
      chk("abort_idle_rk_kept", rk, exp_keys[4]);

      k2 = {$urandom, $urandom, $urandom, $urandom};
      model_expand(k2);
      run_key(k2, 1'b1, 1'b0);
      cmp_all("post_abort");

      // reset mid-expansion
      key = FIPS_KEY; key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0; rk_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_rk_valid_busy", {126'h0, rk_valid, busy}, 128'h0);
      chk("midrst_rk", rk, 128'h0);
      chk("midrst_round_last", {123'h0, rk_round, rk_last}, 128'h0);
      chk("midrst_key_ready", {127'h0, key_ready}, 128'h1);
      repeat (2) @(negedge clk);
      chk("midrst_stays_idle", {127'h0, rk_valid}, 128'h0);
      rk_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
